// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and a
// variable-latency data memory. The stage drives the master side.
interface mem_access_stage_if #(
  parameter int ADDR_W = 12
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage between the XM and MW pipeline latches. Decodes LW/SW,
// runs a req/ack handshake with a variable-latency data memory, stalls
// upstream while an access is outstanding and feeds bubbles into MW.
// Optional feature macro: MEM_TIMEOUT_EN adds an ack watchdog that
// completes a hung access after TIMEOUT BUSY cycles with an exception.
module mem_access_stage #(
  parameter int          ADDR_W  = 12,
  parameter logic [4:0]  OP_SW   = 5'b00111,
  parameter logic [4:0]  OP_LW   = 5'b01000,
  parameter int          TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_ALU_out,
  input  logic [31:0] in_B,
  input  logic [31:0] in_IR,
  input  logic        in_exception,
  output logic        stall,
  output logic [31:0] out_ALU_out,
  output logic [31:0] out_D,
  output logic [31:0] out_IR,
  output logic        out_exception,
  mem_access_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] rd_q;
  logic        is_ld;
  logic        is_st;
  logic        is_ls;
  logic        addr_ok;
  logic        mem_op;
  logic        req;
  logic        expire;
  logic        to_q;

  assign is_ld   = (in_IR[31:27] == OP_LW);
  assign is_st   = (in_IR[31:27] == OP_SW);
  assign is_ls   = is_ld | is_st;
  assign addr_ok = (in_ALU_out[31:ADDR_W] == '0);
  assign mem_op  = is_ls & ~in_exception & addr_ok;

  // Address and store data come straight from XM, which is frozen while busy.
  assign bus.dmem_req   = req;
  assign bus.dmem_we    = req & is_st;
  assign bus.dmem_addr  = in_ALU_out[ADDR_W-1:0];
  assign bus.dmem_wdata = in_B;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  assign expire = (state_q == BUSY) && !bus.dmem_ack &&
                  (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog: counts unacknowledged BUSY cycles; to_q flags the DONE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if ((state_q == BUSY) && !bus.dmem_ack && !expire) cnt_q <= cnt_q + 1'b1;
      else                                               cnt_q <= '0;
      to_q <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign to_q   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Load data latch: captured on ack; stores and timeouts deliver zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (state_q == BUSY) begin
      if (bus.dmem_ack) rd_q <= is_st ? 32'd0 : bus.dmem_rdata;
      else if (expire)  rd_q <= '0;
    end
  end

  // Next state, handshake and MW-facing outputs.
  always_comb begin
    state_d       = state_q;
    req           = 1'b0;
    stall         = 1'b0;
    out_IR        = in_IR;
    out_ALU_out   = in_ALU_out;
    out_D         = '0;
    out_exception = in_exception | (is_ls & ~addr_ok);
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req           = 1'b1;
          stall         = 1'b1;
          out_IR        = '0;
          out_ALU_out   = '0;
          out_exception = 1'b0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        req           = 1'b1;
        stall         = 1'b1;
        out_IR        = '0;
        out_ALU_out   = '0;
        out_exception = 1'b0;
        if (bus.dmem_ack || expire) state_d = DONE;
      end
      DONE: begin
        out_D         = rd_q;
        out_exception = to_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
